divsub_seq: RTL and testbench
=============================

Name: divsub_seq

Overview:
- Iterative unsigned restoring divider, WIDTH bits. Each step is one trial subtraction, the same subtract path as the team's 8-bit add/sub unit (subtract mode is a + ~b + 1).
- Pairs with the add/sub datapath: the add/sub unit builds arithmetic up, this block takes it apart by repeated subtraction.
- Start/done handshake; the result is held until the next accepted start.
- Used by the ALU sequencer for DIV/MOD operations.

Parameters:
- WIDTH, 8, operand/result width in bits. Legal range is 2..16.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- dividend  in  WIDTH  numerator; latched when start is accepted
- divisor  in  WIDTH  denominator; latched when start is accepted
- busy  out  1  high while a division is in progress (CALC/FIX states)
- done  out  1  single-cycle pulse when the result becomes valid
- quotient  out  WIDTH  result; held stable outside CALC
- remainder  out  WIDTH  result; held stable outside CALC
- div_by_zero  out  1  flag for the last completed op; held with the result

Behaviour:
- Reset: the one clock and the synchronous active-high reset are fixed.
  - rst is sampled on the clk rising edge.
  - Forces state to IDLE.
  - Clears busy, done, quotient, remainder and div_by_zero to 0.
  - Discards any operation in flight, regardless of state.
- States: IDLE, CALC, DONE, plus FIX when the optional feature is compiled in.
- IDLE:
  - start=1 with divisor!=0: latch operands, set rem=0, q=dividend, count=WIDTH, go to CALC.
  - start=1 with divisor==0: go to DONE with quotient=all-ones, remainder=dividend, div_by_zero=1.
  - start=0: stay in IDLE; outputs hold.
- CALC, one step per cycle:
  - Shift {rem,q} left by 1.
  - Form the trial value t = {1'b0,rem} - {1'b0,divisor} at WIDTH+1 bits.
  - If t[WIDTH]==0: rem=t[WIDTH-1:0] and q[0]=1. Otherwise the rem restore is kept and q[0]=0.
  - Decrement count. After step WIDTH, go to DONE (or FIX when the feature is enabled).
- DONE:
  - done=1 for exactly this cycle.
  - quotient=q, remainder=rem, div_by_zero=0 on the normal path.
  - Always returns to IDLE next cycle.
- busy=1 in CALC and FIX only.
- Latency, with start accepted at edge 0:
  - Normal op: done is high in cycle WIDTH+1 (cycle 9 for WIDTH=8).
  - Divide-by-zero: done is high in cycle 1.
- Back-to-back: start is ignored in CALC, FIX and DONE. The earliest next accept is the first IDLE cycle after done.
- quotient and remainder do not change while busy. They update on the edge that raises done.
- Operands may change after the accept edge without effect.
- Widths:
  - Internal remainder is WIDTH+1 bits.
  - No overflow is possible in unsigned mode.
  - Invariant: dividend == quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
- Macro: DIVSUB_SEQ_SIGNED_EN.
- Defined: operands are two's complement.
  - On accept, latch the operand magnitudes, sign_q = dividend[MSB]^divisor[MSB], and sign_r = dividend[MSB].
  - CALC runs unchanged. It then enters FIX for one cycle, which negates q if sign_q and rem if sign_r. DONE follows.
  - Normal latency becomes WIDTH+2.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Most-negative / -1 (e.g. 0x80/0xFF) gives quotient=0x80, remainder=0, div_by_zero=0.
  - Divisor 0 behaves as in unsigned mode: quotient=all-ones, remainder=dividend.
- Undefined: no FIX state, unsigned only, latency WIDTH+1.

Test Plan:
- Basic: dividend=0x64, divisor=0x07, start pulse -> done at cycle 9, quotient=0x0E, remainder=0x02, div_by_zero=0.
- Extremes: 0xFF/0x01 -> q=0xFF, r=0x00. 0x05/0x0A -> q=0x00, r=0x05. 0xFF/0xFF -> q=0x01, r=0x00.
- Divide by zero: 0x55/0x00 -> done at cycle 1, q=0xFF, r=0x55, div_by_zero=1, busy never high.
- Handshake: 0x80/0x03 accepted, second start with 0x10/0x02 at cycle 4 -> ignored. Result q=0x2A, r=0x02 at cycle 9. The next start accepted in cycle 10 yields q=0x08, r=0x00 at cycle 19.
- Reset mid-op: rst=1 at cycle 5 of a 0xC8/0x09 divide -> cycle 6 shows all outputs 0 and IDLE. A fresh start then gives q=0x16, r=0x02.
- Signed, DIVSUB_SEQ_SIGNED_EN defined:
  - 0xF9/0x02 -> done at cycle 10, q=0xFD, r=0xFF.
  - 0x80/0xFF -> q=0x80, r=0x00.

Source files
------------

// File: rtl/divsub_seq_if.sv
// Start/done request and result bundle for the divsub_seq iterative divider.
interface divsub_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divsub_seq.sv
// Iterative restoring divider: one trial subtraction (a + ~b + 1) per cycle.
// Define DIVSUB_SEQ_SIGNED_EN for two's-complement operands (adds a FIX cycle).
module divsub_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  divsub_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef DIVSUB_SEQ_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2, FIX = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [WIDTH-1:0] dvs, dvs_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             busy_r, busy_nxt;
  logic             done_r, done_nxt;
  logic [WIDTH-1:0] quot_r, quot_nxt;
  logic [WIDTH-1:0] rmd_r, rmd_nxt;
  logic             dz_r, dz_nxt;
`ifdef DIVSUB_SEQ_SIGNED_EN
  logic             sign_q, sign_q_nxt;
  logic             sign_r, sign_r_nxt;
`endif

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             borrow;

`ifdef DIVSUB_SEQ_SIGNED_EN
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return WIDTH'(~v + WIDTH'(1));
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg(v) : v;
  endfunction
`endif

  // Trial subtraction on the shifted partial remainder; the extra top bit is the borrow.
  always_comb begin
    rem_sh = {rem, q[WIDTH-1]};
    trial  = {1'b0, rem_sh} + ~(WIDTH+2)'(dvs) + (WIDTH+2)'(1);
    borrow = trial[WIDTH+1];
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    q_nxt     = q;
    dvs_nxt   = dvs;
    count_nxt = count;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    quot_nxt  = quot_r;
    rmd_nxt   = rmd_r;
    dz_nxt    = dz_r;
`ifdef DIVSUB_SEQ_SIGNED_EN
    sign_q_nxt = sign_q;
    sign_r_nxt = sign_r;
`endif

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            quot_nxt  = '1;
            rmd_nxt   = bus.dividend;
            dz_nxt    = 1'b1;
          end else begin
            state_nxt = CALC;
            busy_nxt  = 1'b1;
            rem_nxt   = '0;
            count_nxt = CW'(WIDTH);
`ifdef DIVSUB_SEQ_SIGNED_EN
            q_nxt      = mag(bus.dividend);
            dvs_nxt    = mag(bus.divisor);
            sign_q_nxt = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sign_r_nxt = bus.dividend[WIDTH-1];
`else
            q_nxt   = bus.dividend;
            dvs_nxt = bus.divisor;
`endif
          end
        end
      end

      CALC: begin
        // Keep the shifted remainder on borrow (restore), else take the difference.
        q_nxt     = {q[WIDTH-2:0], ~borrow};
        rem_nxt   = WIDTH'(borrow ? rem_sh : trial[WIDTH:0]);
        count_nxt = count - CW'(1);
        if (count == CW'(1)) begin
`ifdef DIVSUB_SEQ_SIGNED_EN
          state_nxt = FIX;
          busy_nxt  = 1'b1;
`else
          state_nxt = DONE;
          done_nxt  = 1'b1;
          quot_nxt  = q_nxt;
          rmd_nxt   = rem_nxt;
          dz_nxt    = 1'b0;
`endif
        end else begin
          busy_nxt = 1'b1;
        end
      end

`ifdef DIVSUB_SEQ_SIGNED_EN
      FIX: begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
        quot_nxt  = sign_q ? neg(q) : q;
        rmd_nxt   = sign_r ? neg(rem) : rem;
        dz_nxt    = 1'b0;
      end
`endif

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      q      <= '0;
      dvs    <= '0;
      count  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      quot_r <= '0;
      rmd_r  <= '0;
      dz_r   <= 1'b0;
`ifdef DIVSUB_SEQ_SIGNED_EN
      sign_q <= 1'b0;
      sign_r <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      q      <= q_nxt;
      dvs    <= dvs_nxt;
      count  <= count_nxt;
      busy_r <= busy_nxt;
      done_r <= done_nxt;
      quot_r <= quot_nxt;
      rmd_r  <= rmd_nxt;
      dz_r   <= dz_nxt;
`ifdef DIVSUB_SEQ_SIGNED_EN
      sign_q <= sign_q_nxt;
      sign_r <= sign_r_nxt;
`endif
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rmd_r;
  assign bus.div_by_zero = dz_r;

endmodule

// File: tb/tb_divsub_seq.sv
// Self-checking bench for divsub_seq: directed vectors plus random ops against
// an arithmetic reference model (signed model when DIVSUB_SEQ_SIGNED_EN is set).
module tb_divsub_seq;

  localparam int unsigned W = 8;
  localparam int MAX_CYC = 60;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  divsub_seq_if #(.WIDTH(W)) bus ();

  divsub_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

`ifdef DIVSUB_SEQ_SIGNED_EN
  vec_t vecs [5] = '{
    '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 10},
    '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 10},
    '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 10},
    '{8'h05, 8'hFB, 8'hFF, 8'h00, 1'b0, 10},
    '{8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1}
  };
`else
  vec_t vecs [5] = '{
    '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 9},
    '{8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 9},
    '{8'h05, 8'h0A, 8'h00, 8'h05, 1'b0, 9},
    '{8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 9},
    '{8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1}
  };
`endif

  // Reference: plain division semantics, latency counted from the accept edge.
  function automatic void model(input logic [W-1:0] dd, input logic [W-1:0] dv,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output int lat);
    if (dv == '0) begin
      q = '1; r = dd; dz = 1'b1; lat = 1;
    end else begin
`ifdef DIVSUB_SEQ_SIGNED_EN
      int a, b;
      a = int'($signed(dd));
      b = int'($signed(dv));
      q = W'(a / b);
      r = W'(a % b);
      lat = W + 2;
`else
      q = dd / dv;
      r = dd % dv;
      lat = W + 1;
`endif
      dz = 1'b0;
    end
  endfunction

  // Drive one op starting at the next cycle; optionally pulse a stray start at glitch_cyc.
  task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input int glitch_cyc,
                        output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output int busy_cyc, output logic held_ok);
    logic [W-1:0] q0, r0;
    @(posedge clk); #1;
    q0 = bus.quotient;
    r0 = bus.remainder;
    bus.start = 1'b1; bus.dividend = dd; bus.divisor = dv;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = W'($urandom); bus.divisor = W'($urandom);
    lat = 1; busy_cyc = 0; held_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < MAX_CYC) begin
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.quotient !== q0 || bus.remainder !== r0) held_ok = 1'b0;
      if (lat == glitch_cyc) begin
        bus.start = 1'b1; bus.dividend = 8'h10; bus.divisor = 8'h02;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    q = bus.quotient; r = bus.remainder; dz = bus.div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", bus.done); end
    n_cmp++; if (bus.quotient !== '0) begin n_bad++; $display("FAIL reset quotient: got %h want 00", bus.quotient); end
    n_cmp++; if (bus.remainder !== '0) begin n_bad++; $display("FAIL reset remainder: got %h want 00", bus.remainder); end
    n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset div_by_zero: got %b want 0", bus.div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    int lat, bc; logic [W-1:0] q, r; logic dz, held;
    foreach (vecs[i]) begin
      run_op(vecs[i].dd, vecs[i].dv, 0, lat, q, r, dz, bc, held);
      n_cmp++; if (lat != vecs[i].lat) begin n_bad++; $display("FAIL vec%0d latency: got %0d want %0d", i, lat, vecs[i].lat); end
      n_cmp++; if (q !== vecs[i].q) begin n_bad++; $display("FAIL vec%0d quotient: got %h want %h", i, q, vecs[i].q); end
      n_cmp++; if (r !== vecs[i].r) begin n_bad++; $display("FAIL vec%0d remainder: got %h want %h", i, r, vecs[i].r); end
      n_cmp++; if (dz !== vecs[i].dz) begin n_bad++; $display("FAIL vec%0d div_by_zero: got %b want %b", i, dz, vecs[i].dz); end
      n_cmp++; if (bc != vecs[i].lat - 1) begin n_bad++; $display("FAIL vec%0d busy cycles: got %0d want %0d", i, bc, vecs[i].lat - 1); end
      n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL vec%0d result held while busy: got %b want 1", i, held); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, elat; logic [W-1:0] q, r, eq, er; logic dz, edz, held;
    run_op(8'h80, 8'h03, 4, lat, q, r, dz, bc, held);
    model(8'h80, 8'h03, eq, er, edz, elat);
    n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL b2b first latency: got %0d want %0d", lat, elat); end
    n_cmp++; if (q !== eq || r !== er) begin n_bad++; $display("FAIL b2b first result: got %h/%h want %h/%h", q, r, eq, er); end
    // Issued in the first IDLE cycle after done; must be accepted right away.
    run_op(8'h10, 8'h02, 0, lat, q, r, dz, bc, held);
    model(8'h10, 8'h02, eq, er, edz, elat);
    n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL b2b second latency: got %0d want %0d", lat, elat); end
    n_cmp++; if (q !== eq || r !== er) begin n_bad++; $display("FAIL b2b second result: got %h/%h want %h/%h", q, r, eq, er); end
  endtask

  task automatic test_reset_mid_op();
    int lat, bc, elat, cyc; logic [W-1:0] q, r, eq, er; logic dz, edz, held;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 8'hC8; bus.divisor = 8'h09;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin @(posedge clk); #1; cyc++; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL midrst done: got %b want 0", bus.done); end
    n_cmp++; if (bus.quotient !== '0) begin n_bad++; $display("FAIL midrst quotient: got %h want 00", bus.quotient); end
    n_cmp++; if (bus.remainder !== '0) begin n_bad++; $display("FAIL midrst remainder: got %h want 00", bus.remainder); end
    n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_bad++; $display("FAIL midrst div_by_zero: got %b want 0", bus.div_by_zero); end
    run_op(8'hC8, 8'h09, 0, lat, q, r, dz, bc, held);
    model(8'hC8, 8'h09, eq, er, edz, elat);
    n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL midrst rerun latency: got %0d want %0d", lat, elat); end
    n_cmp++; if (q !== eq || r !== er) begin n_bad++; $display("FAIL midrst rerun result: got %h/%h want %h/%h", q, r, eq, er); end
  endtask

  task automatic test_random();
    int lat, bc, elat; logic [W-1:0] dd, dv, q, r, eq, er; logic dz, edz, held;
    for (int i = 0; i < 40; i++) begin
      dd = W'($urandom);
      case ($urandom_range(0, 3))
        0:       dv = '0;
        1:       dv = W'($urandom_range(1, 4));
        default: dv = W'($urandom);
      endcase
      model(dd, dv, eq, er, edz, elat);
      run_op(dd, dv, 0, lat, q, r, dz, bc, held);
      n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL rnd%0d %h/%h latency: got %0d want %0d", i, dd, dv, lat, elat); end
      n_cmp++; if (q !== eq) begin n_bad++; $display("FAIL rnd%0d %h/%h quotient: got %h want %h", i, dd, dv, q, eq); end
      n_cmp++; if (r !== er) begin n_bad++; $display("FAIL rnd%0d %h/%h remainder: got %h want %h", i, dd, dv, r, er); end
      n_cmp++; if (dz !== edz) begin n_bad++; $display("FAIL rnd%0d %h/%h div_by_zero: got %b want %b", i, dd, dv, dz, edz); end
      n_cmp++; if (bc != elat - 1) begin n_bad++; $display("FAIL rnd%0d busy cycles: got %0d want %0d", i, bc, elat - 1); end
      n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL rnd%0d result held while busy: got %b want 1", i, held); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
